// File: rtl/synth_pkg.sv
// Shared synth types and default voice geometry used by the waveshaper
// array, the voice mixer and the PWM stage.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        DONE
    } mix_state_t;

    localparam int NUM_CH_DEF   = 12;
    localparam int SAMPLE_W_DEF = 8;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle over WIDTH cycles.
// A zero divisor yields a zero quotient.
module seq_divider #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic             done_q;

    // The load cycle already resolves the first quotient bit.
    always_comb begin
        rem_in = load_i ? '0 : rem_q;
        quo_in = load_i ? dividend_i : quo_q;
        dvs_in = load_i ? divisor_i : dvs_q;
        trial  = {rem_in, quo_in[WIDTH-1]};
        quo_d  = quo_in << 1;
        rem_d  = trial[WIDTH-1:0];
        if (trial >= {1'b0, dvs_in}) begin
            rem_d    = WIDTH'(trial - {1'b0, dvs_in});
            quo_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= divisor_i;
                zero_q <= (divisor_i == '0);
                cnt_q  <= CW'(WIDTH - 1);
                done_q <= (WIDTH == 1);
            end else if (cnt_q != '0) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                cnt_q  <= cnt_q - CW'(1);
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign quotient_o = zero_q ? '0 : quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/voice_mix_engine.sv
// Time-multiplexed voice mixer: snapshot, serial accumulate, then
// normalise by active-voice count or saturating clip.
module voice_mix_engine
    import synth_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       norm_mode,
    input  logic [NUM_CH*SAMPLE_W-1:0] samples,
    input  logic [NUM_CH-1:0]          sample_enable,
    output logic [SAMPLE_W-1:0]        sample_out,
    output logic                       valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam logic [ACC_W-1:0] MAX =
        {{(ACC_W-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

    mix_state_t                 state_q;
    logic [NUM_CH*SAMPLE_W-1:0] samp_q;
    logic [NUM_CH-1:0]          en_q;
    logic                       mode_q;
    logic [IDX_W-1:0]           idx_q;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]        out_q;
    logic                       valid_q;

    logic [SAMPLE_W-1:0]        cur_smp;
    logic                       last_ch;
    logic                       div_load;
    logic                       div_done;
    logic [ACC_W-1:0]           quo;
    logic [SAMPLE_W-1:0]        result;

    always_comb begin
        cur_smp  = samp_q[idx_q*SAMPLE_W +: SAMPLE_W];
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (en_q[idx_q]) begin
            acc_d = acc_q + ACC_W'(cur_smp);
            cnt_d = cnt_q + CNT_W'(1);
        end
        last_ch  = (idx_q == IDX_W'(NUM_CH - 1));
        div_load = (state_q == ACCUM) && last_ch;
        if (mode_q) begin
            result = (quo > MAX) ? '1 : quo[SAMPLE_W-1:0];
        end else begin
            result = (acc_q > MAX) ? '1 : acc_q[SAMPLE_W-1:0];
        end
    end

    seq_divider #(
        .WIDTH(ACC_W)
    ) u_div (
        .clk       (clk),
        .n_rst     (n_rst),
        .load_i    (div_load),
        .dividend_i(acc_d),
        .divisor_i (ACC_W'(cnt_d)),
        .quotient_o(quo),
        .done_o    (div_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            samp_q  <= '0;
            en_q    <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        samp_q  <= samples;
                        en_q    <= sample_enable;
                        mode_q  <= norm_mode;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (last_ch) begin
                        idx_q   <= '0;
                        state_q <= DIVIDE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        out_q   <= result;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sample_out = out_q;
    assign valid      = valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = start && (state_q != IDLE);

endmodule

// File: tb/tb_voice_mix_engine.sv
// Directed bench for voice_mix_engine: default 12x8 build and a 4x10 build.
module tb_voice_mix_engine;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;

    logic        b_start = 1'b0;
    logic        b_mode = 1'b0;
    logic [95:0] b_smp = '0;
    logic [11:0] b_en = '0;
    logic [7:0]  b_out;
    logic        b_valid, b_busy, b_ovr;

    logic        s_start = 1'b0;
    logic        s_mode = 1'b0;
    logic [39:0] s_smp = '0;
    logic [3:0]  s_en = '0;
    logic [9:0]  s_out;
    logic        s_valid, s_busy, s_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    voice_mix_engine u_big (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (b_start),
        .norm_mode    (b_mode),
        .samples      (b_smp),
        .sample_enable(b_en),
        .sample_out   (b_out),
        .valid        (b_valid),
        .busy         (b_busy),
        .overrun      (b_ovr)
    );

    voice_mix_engine #(
        .NUM_CH  (4),
        .SAMPLE_W(10)
    ) u_small (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (s_start),
        .norm_mode    (s_mode),
        .samples      (s_smp),
        .sample_enable(s_en),
        .sample_out   (s_out),
        .valid        (s_valid),
        .busy         (s_busy),
        .overrun      (s_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_big(input logic [7:0] v);
        for (int k = 0; k < 12; k++) b_smp[k*8 +: 8] = v;
    endtask

    task automatic run_big(input string tag, input logic mode,
                           input logic [7:0] expv);
        int lat;
        lat = -1;
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = mode;
        @(negedge clk);
        b_start = 1'b0;
        chk({tag, "_busy"}, b_busy, 1);
        for (int k = 1; k <= 40; k++) begin
            if (b_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, 25);
        chk({tag, "_out"}, b_out, expv);
        @(negedge clk);
        chk({tag, "_vpulse"}, b_valid, 0);
    endtask

    task automatic run_small(input string tag, input logic mode,
                             input logic [9:0] expv);
        int lat;
        lat = -1;
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = mode;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (s_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, 17);
        chk({tag, "_out"}, s_out, expv);
    endtask

    initial begin
        int nv;
        int lat;
        logic [7:0] vout;

        repeat (3) @(negedge clk);
        chk("rst_out", b_out, 0);
        chk("rst_valid", b_valid, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_ovr", b_ovr, 0);
        chk("rst_s_out", s_out, 0);
        n_rst = 1'b1;
        @(negedge clk);

        fill_big(8'd255);
        b_smp[0*8 +: 8] = 8'd90;
        b_smp[4*8 +: 8] = 8'd120;
        b_smp[7*8 +: 8] = 8'd30;
        b_en = 12'h091;
        run_big("div3", 1'b1, 8'd80);

        fill_big(8'd200);
        b_en = 12'hfff;
        run_big("clip_all", 1'b0, 8'd255);

        fill_big(8'd0);
        b_smp[1*8 +: 8] = 8'd50;
        b_smp[2*8 +: 8] = 8'd60;
        b_en = 12'h006;
        run_big("clip_2", 1'b0, 8'd110);

        fill_big(8'd255);
        b_en = 12'h000;
        run_big("div_zero", 1'b1, 8'd0);

        fill_big(8'd0);
        b_smp[0*8 +: 8] = 8'd100;
        b_smp[1*8 +: 8] = 8'd101;
        b_en = 12'h003;
        run_big("div_floor", 1'b1, 8'd100);

        // snapshot isolation plus overrun at T+10
        fill_big(8'd0);
        b_smp[0*8 +: 8] = 8'd10;
        b_smp[1*8 +: 8] = 8'd20;
        b_smp[2*8 +: 8] = 8'd33;
        b_en = 12'h007;
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        nv = 0;
        lat = -1;
        vout = '0;
        for (int k = 1; k <= 40; k++) begin
            b_smp  = {$urandom, $urandom, $urandom};
            b_en   = 12'($urandom);
            b_mode = 1'($urandom);
            if (k == 10) begin
                b_start = 1'b1;
                #1;
                chk("ovr_pulse", b_ovr, 1);
            end
            if (b_valid) begin
                nv++;
                lat = k;
                vout = b_out;
            end
            @(negedge clk);
            b_start = 1'b0;
        end
        chk("ovr_nvalid", nv, 1);
        chk("ovr_lat", lat, 25);
        chk("ovr_out", vout, 8'd21);
        chk("ovr_idle_ovr", b_ovr, 0);

        // reset mid-operation at T+15
        fill_big(8'd255);
        b_en = 12'hfff;
        @(negedge clk);
        b_start = 1'b1;
        b_mode  = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        repeat (14) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("abort_out", b_out, 0);
        chk("abort_valid", b_valid, 0);
        chk("abort_busy", b_busy, 0);
        chk("abort_ovr", b_ovr, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 30; k++) begin
            if (b_valid) nv++;
            @(negedge clk);
        end
        chk("abort_novalid", nv, 0);

        fill_big(8'd0);
        b_smp[3*8 +: 8] = 8'd77;
        b_smp[5*8 +: 8] = 8'd100;
        b_en = 12'h028;
        run_big("post_rst", 1'b0, 8'd177);

        s_smp = {4{10'd1023}};
        s_en  = 4'hf;
        run_small("s_div_all", 1'b1, 10'd1023);

        s_en = 4'h3;
        run_small("s_clip_sat", 1'b0, 10'd1023);

        s_smp = {10'd7, 10'd100, 10'd300, 10'd500};
        s_en  = 4'h3;
        run_small("s_clip_800", 1'b0, 10'd800);

        s_en = 4'h7;
        run_small("s_div_300", 1'b1, 10'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
